// File: rtl/start_rdy_timer.sv
// -----------------------------------------------------------------------------
// start_rdy_timer
//
// Responder side of the START/RDY handshake used by the control FSMs. A
// one-cycle START pulse arms a countdown of max(PERIOD,1) ticks. RDY drops on
// the START edge and rises again on the edge where the count expires. DONE
// pulses for one cycle on natural expiry only. CANCEL aborts a running count
// without a DONE pulse. A START while running reloads the count (retrigger).
//
// Optional build macro: TIMER_PRESCALE_EN
//   Defined   : one count tick every PRESCALE clocks while running.
//   Undefined : one count tick every clock; PRESCALE is not used by logic.
//
// Parameters:
//   WIDTH    - width of PERIOD and REMAIN
//   PRESCALE - clocks per tick when TIMER_PRESCALE_EN is defined (>= 1)
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-high reset
//   START   in   arm / retrigger request
//   CANCEL  in   abort running count (wins over START)
//   PERIOD  in   countdown length in ticks, captured on accepted START only
//   RDY     out  high when idle, low while counting (registered)
//   DONE    out  one-cycle pulse on natural expiry (registered)
//   REMAIN  out  ticks remaining while running, 0 when idle (registered)
// -----------------------------------------------------------------------------
module start_rdy_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             START,
  input  logic             CANCEL,
  input  logic [WIDTH-1:0] PERIOD,
  output logic             RDY,
  output logic             DONE,
  output logic [WIDTH-1:0] REMAIN
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic             rdy_r;
  logic             done_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] load_val_s;
  logic             tick_s;
  logic             count_zero_s;

  // A prescaler of zero clocks per tick has no meaning; reject at elaboration.
  if (PRESCALE < 1) begin : g_prescale_check
    $error("start_rdy_timer: PRESCALE must be >= 1");
  end

  // Reload value: PERIOD of zero behaves as one tick, so the count starts at 0.
  always_comb begin
    load_val_s = {WIDTH{1'b0}};
    if (PERIOD == {WIDTH{1'b0}}) begin
      load_val_s = {WIDTH{1'b0}};
    end else begin
      load_val_s = PERIOD - WIDTH'(1);
    end
  end

  // Expiry is checked before decrement, so the counter never wraps below zero.
  always_comb begin
    count_zero_s = 1'b0;
    if (count_r == {WIDTH{1'b0}}) begin
      count_zero_s = 1'b1;
    end else begin
      count_zero_s = 1'b0;
    end
  end

`ifdef TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_r;
  logic          pre_run_s;

  // Tick on the last prescaler phase of each period while running.
  always_comb begin
    tick_s = 1'b0;
    if (pre_r == PRE_LAST) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Prescaler only advances in an undisturbed RUN cycle that is not a tick;
  // START, CANCEL, tick (wrap or expiry) and IDLE all return it to phase 0.
  always_comb begin
    pre_run_s = 1'b0;
    if ((state_r == RUN) && !START && !CANCEL && !tick_s) begin
      pre_run_s = 1'b1;
    end else begin
      pre_run_s = 1'b0;
    end
  end

  // Prescaler phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_r <= {PW{1'b0}};
    end else if (pre_run_s) begin
      pre_r <= pre_r + PW'(1);
    end else begin
      pre_r <= {PW{1'b0}};
    end
  end
`else
  // Without the prescaler every clock is a count tick.
  assign tick_s = 1'b1;
`endif

  // Main controller: state, countdown and the registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      rdy_r   <= 1'b1;
      done_r  <= 1'b0;
      count_r <= {WIDTH{1'b0}};
    end else begin
      // DONE is a single-cycle pulse unless expiry re-asserts it below.
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (START && !CANCEL) begin
            state_r <= RUN;
            rdy_r   <= 1'b0;
            count_r <= load_val_s;
          end else begin
            state_r <= IDLE;
            rdy_r   <= 1'b1;
            count_r <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          if (CANCEL) begin
            // Abort: back to idle without DONE.
            state_r <= IDLE;
            rdy_r   <= 1'b1;
            count_r <= {WIDTH{1'b0}};
          end else if (START) begin
            // Retrigger: reload from the PERIOD presented on this edge.
            state_r <= RUN;
            rdy_r   <= 1'b0;
            count_r <= load_val_s;
          end else if (tick_s && count_zero_s) begin
            // Natural expiry.
            state_r <= IDLE;
            rdy_r   <= 1'b1;
            done_r  <= 1'b1;
            count_r <= {WIDTH{1'b0}};
          end else if (tick_s) begin
            state_r <= RUN;
            rdy_r   <= 1'b0;
            count_r <= count_r - WIDTH'(1);
          end else begin
            state_r <= RUN;
            rdy_r   <= 1'b0;
            count_r <= count_r;
          end
        end
        default: begin
          state_r <= IDLE;
          rdy_r   <= 1'b1;
          count_r <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // The counter is held at zero in IDLE, so it doubles as REMAIN.
  assign RDY    = rdy_r;
  assign DONE   = done_r;
  assign REMAIN = count_r;

endmodule

// File: tb/tb_start_rdy_timer.sv
// -----------------------------------------------------------------------------
// tb_start_rdy_timer
//
// Self-checking bench for start_rdy_timer. A deadline-based reference model
// (accepted START at edge n expires at edge n + max(P,1)*PS) predicts RDY,
// DONE and REMAIN; a compare process checks them at every falling edge.
// Directed sequences add literal expectations, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_start_rdy_timer;

  localparam int WIDTH = 16;
`ifdef TIMER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic             clk;
  logic             reset;
  logic             START;
  logic             CANCEL;
  logic [WIDTH-1:0] PERIOD;
  logic             RDY;
  logic             DONE;
  logic [WIDTH-1:0] REMAIN;

  int tests;
  int fails;
  bit chk_en;

  // reference model state
  int m_cyc;
  bit m_busy;
  bit m_done;
  int m_deadline;

  start_rdy_timer #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .START  (START),
    .CANCEL (CANCEL),
    .PERIOD (PERIOD),
    .RDY    (RDY),
    .DONE   (DONE),
    .REMAIN (REMAIN)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: updated on each rising edge from the sampled inputs.
  initial begin
    int eff;
    m_cyc = 0; m_busy = 1'b0; m_done = 1'b0; m_deadline = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end else begin
        m_cyc++;
        m_done = 1'b0;
        eff = (PERIOD == 16'd0) ? 1 : int'(PERIOD);
        if (m_busy) begin
          if (CANCEL) m_busy = 1'b0;
          else if (START) m_deadline = m_cyc + eff * PS;
          else if (m_cyc == m_deadline) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end else if (START && !CANCEL) begin
          m_busy = 1'b1;
          m_deadline = m_cyc + eff * PS;
        end
      end
    end
  end

  // Compare process: DUT against model at every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model.rdy", int'(RDY), m_busy ? 0 : 1);
        check("model.done", int'(DONE), int'(m_done));
        check("model.remain", int'(REMAIN), m_busy ? (m_deadline - m_cyc - 1) / PS : 0);
      end
    end
  end

  task automatic drive(input logic s, input logic c, input int p);
    START = s;
    CANCEL = c;
    PERIOD = 16'(p);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string n, input int r, input int d, input int rem);
    check({n, ".rdy"}, int'(RDY), r);
    check({n, ".done"}, int'(DONE), d);
    check({n, ".remain"}, int'(REMAIN), rem);
  endtask

  initial begin
    int lows;
    int dones;
    int n;
    tests = 0; fails = 0; chk_en = 1'b0;
    START = 1'b0; CANCEL = 1'b0; PERIOD = 16'd0;
    reset = 1'b1;
    #1;
    expect_out("in_reset", 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // idle after reset
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 7);
    expect_out("idle5", 1, 0, 0);

`ifndef TIMER_PRESCALE_EN
    // PERIOD=5: REMAIN 4,3,2,1,0 then RDY+DONE rise together
    drive(1'b1, 1'b0, 5);
    expect_out("p5.e0", 0, 0, 4);
    for (int k = 3; k >= 0; k--) begin
      drive(1'b0, 1'b0, 9);
      expect_out("p5.run", 0, 0, k);
    end
    drive(1'b0, 1'b0, 9);
    expect_out("p5.exp", 1, 1, 0);
    drive(1'b0, 1'b0, 9);
    expect_out("p5.after", 1, 0, 0);

    // PERIOD=0 and PERIOD=1: one-cycle low window
    for (int p = 0; p < 2; p++) begin
      drive(1'b1, 1'b0, p);
      expect_out("p01.low", 0, 0, 0);
      drive(1'b0, 1'b0, 4);
      expect_out("p01.exp", 1, 1, 0);
    end

    // retrigger at edge 3 with PERIOD=8 -> 11 low cycles, one DONE
    lows = 0; dones = 0;
    drive(1'b1, 1'b0, 8); lows += RDY ? 0 : 1;
    drive(1'b0, 1'b0, 8); lows += RDY ? 0 : 1;
    drive(1'b0, 1'b0, 8); lows += RDY ? 0 : 1;
    drive(1'b1, 1'b0, 8); lows += RDY ? 0 : 1;
    n = 0;
    while (RDY == 1'b0 && n < 40) begin
      drive(1'b0, 1'b0, 2);
      lows += RDY ? 0 : 1;
      dones += DONE ? 1 : 0;
      n++;
    end
    check("retrig.timeout", (n < 40) ? 1 : 0, 1);
    check("retrig.lows", lows, 11);
    check("retrig.dones", dones, 1);

    // controller-style back-to-back, PERIOD=3
    drive(1'b1, 1'b0, 3);
    expect_out("b2b.a0", 0, 0, 2);
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b0, 3);
    expect_out("b2b.a2", 0, 0, 0);
    drive(1'b0, 1'b0, 3);
    expect_out("b2b.rise", 1, 1, 0);
    drive(1'b1, 1'b0, 3);
    expect_out("b2b.b0", 0, 0, 2);
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b0, 3);
    expect_out("b2b.b2", 0, 0, 0);
    drive(1'b0, 1'b0, 3);
    expect_out("b2b.rise2", 1, 1, 0);
`else
    // prescaled: PERIOD=3, PRESCALE=4 -> 12 low cycles
    drive(1'b1, 1'b0, 3);
    expect_out("ps.e0", 0, 0, 2);
    for (int k = 1; k < 12; k++) begin
      drive(1'b0, 1'b0, 6);
      expect_out("ps.run", 0, 0, (k < 4) ? 2 : ((k < 8) ? 1 : 0));
    end
    drive(1'b0, 1'b0, 6);
    expect_out("ps.exp", 1, 1, 0);
`endif

    // CANCEL at edge 2 of a run
    drive(1'b1, 1'b0, 8);
    drive(1'b0, 1'b0, 8);
    drive(1'b0, 1'b1, 8);
    expect_out("cancel", 1, 0, 0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 8);
    expect_out("cancel.quiet", 1, 0, 0);

    // START with CANCEL in IDLE does not start
    drive(1'b1, 1'b1, 5);
    expect_out("stcan.idle", 1, 0, 0);

    // asynchronous reset mid-count, PERIOD=10
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 10);
    drive(1'b0, 1'b0, 10);
    check("arst.pre.rdy", int'(RDY), 0);
    #2 reset = 1'b1;
    #1;
    expect_out("arst.async", 1, 0, 0);
    drive(1'b0, 1'b0, 10);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 10);
    expect_out("arst.quiet", 1, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        drive(1'b0, 1'b0, 0);
        reset = 1'b0;
      end else begin
        drive(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
              int'($urandom_range(0, 15)));
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
